// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the 5-stage MIPS pipeline. A small
// per-register latency scoreboard replaces the fixed load-use and branch
// comparators. Producers with variable latency (ALU, load, multi-cycle mul/div)
// therefore hold their dependent instructions in ID for exactly as many cycles
// as they need. The block also produces the E-stage and D-stage forwarding
// selects, and it holds branch redirects off for a short warm-up after reset.
//
// Optional feature macro: HAZ_STATS_EN
//   Defined   -> the stall_cycles / branch_stalls counters and their ports exist.
//   Undefined -> those ports do not exist. All other behaviour is identical.
//
// Parameters
//   REG_AW  register address width (NREG = 2**REG_AW scoreboard entries)
//   LAT_W   scoreboard counter width (max producer latency 2**LAT_W - 2)
//   WARMUP  cycles after reset release during which branch_en stays low
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   issue_d, is_branch_d         valid ID instruction / it resolves in ID
//   rs_d, rt_d, use_rs_d, use_rt_d   ID sources and whether each one is read
//   wr_en_d, wr_reg_d, lat_d     ID destination and its producer latency
//   ex_busy                      multi-cycle unit in EX has not finished
//   rs_e, rt_e                   EX sources (used for E-stage forwarding)
//   wr_reg_m, reg_write_m        M-stage destination / write enable
//   wr_reg_w, reg_write_w        W-stage destination / write enable
//   stall_f, stall_d, flush_e    pipeline controls
//   fwd_a_e, fwd_b_e             00 regfile, 01 ResultW, 10 ALUOutM
//   fwd_a_d, fwd_b_d             1 = branch comparator takes ALUOutM
//   branch_en                    branch redirect permitted
//   sb_busy                      bit r set while scoreboard entry r is nonzero
//   stall_cycles, branch_stalls  (HAZ_STATS_EN only) wrapping statistics
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int WARMUP = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     issue_d,
    input  logic                     is_branch_d,
    input  logic [REG_AW-1:0]        rs_d,
    input  logic [REG_AW-1:0]        rt_d,
    input  logic                     use_rs_d,
    input  logic                     use_rt_d,
    input  logic                     wr_en_d,
    input  logic [REG_AW-1:0]        wr_reg_d,
    input  logic [LAT_W-1:0]         lat_d,

    input  logic                     ex_busy,
    input  logic [REG_AW-1:0]        rs_e,
    input  logic [REG_AW-1:0]        rt_e,
    input  logic [REG_AW-1:0]        wr_reg_m,
    input  logic [REG_AW-1:0]        wr_reg_w,
    input  logic                     reg_write_m,
    input  logic                     reg_write_w,

    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     flush_e,
    output logic [1:0]               fwd_a_e,
    output logic [1:0]               fwd_b_e,
    output logic                     fwd_a_d,
    output logic                     fwd_b_d,
    output logic                     branch_en,
    output logic [(1<<REG_AW)-1:0]   sb_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              branch_stalls
`endif
);

    localparam int NREG = 1 << REG_AW;
    localparam int WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    // Current value of every scoreboard counter, one LAT_W slice per register.
    logic [NREG-1:0][LAT_W-1:0] cnt_all;

    logic [LAT_W-1:0] cnt_rs;
    logic [LAT_W-1:0] cnt_rt;
    logic             haz_rs;
    logic             haz_rt;
    logic             raw_stall;
    logic             issue_evt;
    logic             set_en;
    logic [LAT_W-1:0] set_val;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    // A branch reads its operands in ID, so it needs the value one cycle earlier
    // than an EX consumer. An EX consumer is satisfied by ALUOutM/ResultW
    // forwarding once the counter reaches 1. A branch has to wait until 0.
    // A self-dependency (source == destination) needs no special handling:
    // the check sees the old count, and the new value is set only at the clock edge.
    always_comb begin
        cnt_rs = cnt_all[rs_d];
        cnt_rt = cnt_all[rt_d];
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        if (use_rs_d && (rs_d != '0)) begin
            haz_rs = is_branch_d ? (cnt_rs != '0) : (cnt_rs > LAT_W'(1));
        end
        if (use_rt_d && (rt_d != '0)) begin
            haz_rt = is_branch_d ? (cnt_rt != '0) : (cnt_rt > LAT_W'(1));
        end
    end

    assign raw_stall = issue_d && (haz_rs || haz_rt);
    assign stall_d   = raw_stall || ex_busy;
    assign stall_f   = stall_d;
    // Insert a bubble only when EX actually advances. While ex_busy holds EX,
    // the instruction already in EX must stay there.
    assign flush_e   = raw_stall && !ex_busy;

    assign issue_evt = issue_d && !stall_d && !ex_busy;
    assign set_en    = issue_evt && wr_en_d && (wr_reg_d != '0);
    assign set_val   = lat_d + LAT_W'(1);

    // -------------------------------------------------------------------------
    // Scoreboard counters
    // -------------------------------------------------------------------------
    // Every nonzero counter counts down on each cycle in which EX advances.
    // While ex_busy is high the whole scoreboard is frozen. A new issue to the
    // same register overrides the decrement.
    // Entry 0 is hard-wired to zero because $0 never carries a real value.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_all[gi] = '0;
                assign sb_busy[gi] = 1'b0;
            end else begin : g_entry
                logic [LAT_W-1:0] cnt_q;
                logic [LAT_W-1:0] cnt_d;

                always_comb begin
                    cnt_d = cnt_q;
                    if (!ex_busy) begin
                        if (set_en && (wr_reg_d == REG_AW'(gi))) begin
                            cnt_d = set_val;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - LAT_W'(1);
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_all[gi] = cnt_q;
                assign sb_busy[gi] = (cnt_q != '0);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Forwarding selects
    // -------------------------------------------------------------------------
    // The M stage holds the newer value, so it wins over W.
    always_comb begin
        fwd_a_e = 2'b00;
        if (reg_write_m && (wr_reg_m == rs_e) && (rs_e != '0)) begin
            fwd_a_e = 2'b10;
        end else if (reg_write_w && (wr_reg_w == rs_e) && (rs_e != '0)) begin
            fwd_a_e = 2'b01;
        end

        fwd_b_e = 2'b00;
        if (reg_write_m && (wr_reg_m == rt_e) && (rt_e != '0)) begin
            fwd_b_e = 2'b10;
        end else if (reg_write_w && (wr_reg_w == rt_e) && (rt_e != '0)) begin
            fwd_b_e = 2'b01;
        end
    end

    // ID only forwards from M. W results reach ID through the write-through
    // regfile.
    assign fwd_a_d = reg_write_m && (wr_reg_m == rs_d) && (rs_d != '0);
    assign fwd_b_d = reg_write_m && (wr_reg_m == rt_d) && (rt_d != '0);

    // -------------------------------------------------------------------------
    // Branch warm-up
    // -------------------------------------------------------------------------
    logic [WC_W-1:0] wc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q <= '0;
        end else if (wc_q != WC_W'(WARMUP)) begin
            wc_q <= wc_q + WC_W'(1);
        end
    end

    assign branch_en = (wc_q == WC_W'(WARMUP));

`ifdef HAZ_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics (free-running, wrap at 2**32)
    // -------------------------------------------------------------------------
    logic [31:0] stall_cycles_q;
    logic [31:0] branch_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q  <= '0;
            branch_stalls_q <= '0;
        end else begin
            if (stall_d) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (raw_stall && is_branch_d) begin
                branch_stalls_q <= branch_stalls_q + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign branch_stalls = branch_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard: directed scenarios plus a randomized run
// that is checked against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;
    localparam int WARMUP = 3;
    localparam int NREG   = 1 << REG_AW;
    localparam int N_RND  = 400;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_d, is_branch_d, use_rs_d, use_rt_d, wr_en_d;
    logic [REG_AW-1:0] rs_d, rt_d, wr_reg_d;
    logic [LAT_W-1:0]  lat_d;
    logic              ex_busy;
    logic [REG_AW-1:0] rs_e, rt_e, wr_reg_m, wr_reg_w;
    logic              reg_write_m, reg_write_w;
    logic              stall_f, stall_d, flush_e;
    logic [1:0]        fwd_a_e, fwd_b_e;
    logic              fwd_a_d, fwd_b_d, branch_en;
    logic [NREG-1:0]   sb_busy;
`ifdef HAZ_STATS_EN
    logic [31:0]       stall_cycles, branch_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .LAT_W  (LAT_W),
        .WARMUP (WARMUP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_d     (issue_d),
        .is_branch_d (is_branch_d),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .use_rs_d    (use_rs_d),
        .use_rt_d    (use_rt_d),
        .wr_en_d     (wr_en_d),
        .wr_reg_d    (wr_reg_d),
        .lat_d       (lat_d),
        .ex_busy     (ex_busy),
        .rs_e        (rs_e),
        .rt_e        (rt_e),
        .wr_reg_m    (wr_reg_m),
        .wr_reg_w    (wr_reg_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_e     (flush_e),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e),
        .fwd_a_d     (fwd_a_d),
        .fwd_b_d     (fwd_b_d),
        .branch_en   (branch_en),
        .sb_busy     (sb_busy)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .branch_stalls (branch_stalls)
`endif
    );

    task automatic idle_inputs();
        issue_d = 1'b0; is_branch_d = 1'b0; use_rs_d = 1'b0; use_rt_d = 1'b0;
        wr_en_d = 1'b0; rs_d = '0; rt_d = '0; wr_reg_d = '0; lat_d = '0;
        ex_busy = 1'b0; rs_e = '0; rt_e = '0; wr_reg_m = '0; wr_reg_w = '0;
        reg_write_m = 1'b0; reg_write_w = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset held: every output must be at its reset value.
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        wait_cycles(2);
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL reset stall_d: got %b exp 0", stall_d); end
        n_vec++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL reset stall_f: got %b exp 0", stall_f); end
        n_vec++; if (flush_e !== 1'b0) begin n_err++; $display("FAIL reset flush_e: got %b exp 0", flush_e); end
        n_vec++; if (branch_en !== 1'b0) begin n_err++; $display("FAIL reset branch_en: got %b exp 0", branch_en); end
        n_vec++; if (sb_busy !== '0) begin n_err++; $display("FAIL reset sb_busy: got %h exp 0", sb_busy); end
        n_vec++; if ({fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d} !== 6'b0) begin
            n_err++; $display("FAIL reset fwd: got %b%b%b%b exp 0", fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d);
        end
        $display("reset: outputs sampled");
    endtask

    // Reset release: branch_en low for cycles 0..WARMUP-1 and high afterwards.
    task automatic test_warmup();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_vec++;
            if (branch_en !== (k >= WARMUP)) begin
                n_err++; $display("FAIL warmup branch_en cyc %0d: got %b exp %b", k, branch_en, (k >= WARMUP));
            end
            n_vec++;
            if (stall_d !== 1'b0) begin
                n_err++; $display("FAIL warmup stall_d cyc %0d: got %b exp 0", k, stall_d);
            end
            $display("warmup cyc %0d branch_en=%b", k, branch_en);
        end
    endtask

    // Load to $8, dependent add: one stall/flush cycle, then ResultW forwarding.
    task automatic test_load_use();
        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd8; lat_d = 3'd1;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL load_use issue stall_d: got %b exp 0", stall_d); end
        @(negedge clk);
        idle_inputs();
        issue_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd8; wr_en_d = 1'b1; wr_reg_d = 5'd12; lat_d = 3'd0;
        #1;
        n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL load_use stall_d c1: got %b exp 1", stall_d); end
        n_vec++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL load_use stall_f c1: got %b exp 1", stall_f); end
        n_vec++; if (flush_e !== 1'b1) begin n_err++; $display("FAIL load_use flush_e c1: got %b exp 1", flush_e); end
        @(negedge clk); #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL load_use stall_d c2: got %b exp 0", stall_d); end
        n_vec++; if (flush_e !== 1'b0) begin n_err++; $display("FAIL load_use flush_e c2: got %b exp 0", flush_e); end
        @(negedge clk);
        idle_inputs();
        rs_e = 5'd8; reg_write_w = 1'b1; wr_reg_w = 5'd8;
        #1;
        n_vec++; if (fwd_a_e !== 2'b01) begin n_err++; $display("FAIL load_use fwd_a_e: got %b exp 01", fwd_a_e); end
        $display("load_use: done");
    endtask

    // Branch on an ALU result (1 stall), then on a load result (2 stalls).
    task automatic test_branch();
        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd9; lat_d = 3'd0;
        @(negedge clk);
        idle_inputs();
        issue_d = 1'b1; is_branch_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd9;
        #1;
        n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL branch_alu stall_d c1: got %b exp 1", stall_d); end
        @(negedge clk);
        reg_write_m = 1'b1; wr_reg_m = 5'd9;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL branch_alu stall_d c2: got %b exp 0", stall_d); end
        n_vec++; if (fwd_a_d !== 1'b1) begin n_err++; $display("FAIL branch_alu fwd_a_d: got %b exp 1", fwd_a_d); end
        n_vec++; if (fwd_b_d !== 1'b0) begin n_err++; $display("FAIL branch_alu fwd_b_d: got %b exp 0", fwd_b_d); end
        $display("branch_alu: done");

        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd9; lat_d = 3'd1;
        @(negedge clk);
        idle_inputs();
        issue_d = 1'b1; is_branch_d = 1'b1; use_rt_d = 1'b1; rt_d = 5'd9;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            n_vec++;
            if (stall_d !== (k <= 2)) begin
                n_err++; $display("FAIL branch_load stall_d c%0d: got %b exp %b", k, stall_d, (k <= 2));
            end
        end
        $display("branch_load: done");
    endtask

    // Divide with latency 5, ex_busy high for cycles 2..4 after issue.
    task automatic test_div_freeze();
        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd10; lat_d = 3'd5;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            idle_inputs();
            issue_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd10;
            ex_busy = (k >= 2 && k <= 4);
            #1;
            // 5 live cycles plus 3 frozen cycles -> stalled for k = 1..8
            n_vec++;
            if (stall_d !== (k <= 8)) begin
                n_err++; $display("FAIL div stall_d c%0d: got %b exp %b", k, stall_d, (k <= 8));
            end
            n_vec++;
            if (flush_e !== ((k <= 8) && !ex_busy)) begin
                n_err++; $display("FAIL div flush_e c%0d: got %b exp %b", k, flush_e, ((k <= 8) && !ex_busy));
            end
            $display("div cyc %0d ex_busy=%b stall_d=%b flush_e=%b", k, ex_busy, stall_d, flush_e);
        end
    endtask

    // Writes to $0 never mark busy; M/W both targeting $11 -> M wins.
    task automatic test_zero_reg();
        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd0; lat_d = 3'd7;
        @(negedge clk);
        idle_inputs();
        issue_d = 1'b1; is_branch_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd0;
        rs_e = 5'd11; rt_e = 5'd11;
        reg_write_m = 1'b1; wr_reg_m = 5'd11; reg_write_w = 1'b1; wr_reg_w = 5'd11;
        #1;
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL zero stall_d: got %b exp 0", stall_d); end
        n_vec++; if (sb_busy !== '0) begin n_err++; $display("FAIL zero sb_busy: got %h exp 0", sb_busy); end
        n_vec++; if (fwd_a_e !== 2'b10) begin n_err++; $display("FAIL mw_prio fwd_a_e: got %b exp 10", fwd_a_e); end
        n_vec++; if (fwd_b_e !== 2'b10) begin n_err++; $display("FAIL mw_prio fwd_b_e: got %b exp 10", fwd_b_e); end
        @(negedge clk);
        rs_e = 5'd0; wr_reg_m = 5'd0; wr_reg_w = 5'd0;
        #1;
        n_vec++; if (fwd_a_e !== 2'b00) begin n_err++; $display("FAIL zero fwd_a_e: got %b exp 00", fwd_a_e); end
        $display("zero_reg: done");
    endtask

    // Reset asserted while cnt[8] = 2 clears the scoreboard at once.
    task automatic test_reset_mid();
        idle_inputs(); wait_cycles(8);
        @(negedge clk);
        issue_d = 1'b1; wr_en_d = 1'b1; wr_reg_d = 5'd8; lat_d = 3'd1;
        @(negedge clk);
        idle_inputs();
        issue_d = 1'b1; use_rs_d = 1'b1; rs_d = 5'd8;
        #1;
        n_vec++; if (sb_busy[8] !== 1'b1) begin n_err++; $display("FAIL rst_mid busy_before: got %b exp 1", sb_busy[8]); end
        n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL rst_mid stall_before: got %b exp 1", stall_d); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (sb_busy !== '0) begin n_err++; $display("FAIL rst_mid sb_busy: got %h exp 0", sb_busy); end
        n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL rst_mid stall_d: got %b exp 0", stall_d); end
        n_vec++; if (branch_en !== 1'b0) begin n_err++; $display("FAIL rst_mid branch_en: got %b exp 0", branch_en); end
`ifdef HAZ_STATS_EN
        n_vec++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_mid stall_cycles: got %0d exp 0", stall_cycles); end
`endif
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        $display("reset_mid: done");
    endtask

    // Randomized traffic against a timestamp model. A counts the cycles in
    // which the pipeline advanced (ex_busy low). A producer issued when the count
    // is A_t with latency L has its value usable by an EX consumer once
    // A >= A_t + L + 1. A branch needs one more cycle. Never-written registers
    // start with a ready time of -1.
    task automatic test_random();
        int ready_at[NREG];
        int a_cnt;
        int ncyc;
        logic e_rs, e_rt, e_raw, e_stall, e_flush, e_fad, e_fbd, e_ben;
        logic [1:0] e_fa, e_fb;
        logic [NREG-1:0] e_busy;
`ifdef HAZ_STATS_EN
        logic [31:0] e_scyc = '0;
`endif
        for (int r = 0; r < NREG; r++) ready_at[r] = -1;
        a_cnt = 0;
        ncyc  = 0;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_RND; i++) begin
            issue_d     = ($urandom_range(0, 9) < 8);
            is_branch_d = ($urandom_range(0, 3) == 0);
            use_rs_d    = ($urandom_range(0, 3) != 0);
            use_rt_d    = ($urandom_range(0, 1) != 0);
            rs_d        = REG_AW'($urandom_range(0, 4));
            rt_d        = REG_AW'($urandom_range(0, 4));
            wr_en_d     = ($urandom_range(0, 1) != 0);
            wr_reg_d    = REG_AW'($urandom_range(0, 4));
            lat_d       = LAT_W'($urandom_range(0, 6));
            ex_busy     = ($urandom_range(0, 6) == 0);
            rs_e        = REG_AW'($urandom_range(0, 3));
            rt_e        = REG_AW'($urandom_range(0, 3));
            wr_reg_m    = REG_AW'($urandom_range(0, 3));
            wr_reg_w    = REG_AW'($urandom_range(0, 3));
            reg_write_m = ($urandom_range(0, 1) != 0);
            reg_write_w = ($urandom_range(0, 1) != 0);
            #1;
            e_rs = use_rs_d && (rs_d != 0) && (a_cnt < ready_at[rs_d] + (is_branch_d ? 1 : 0));
            e_rt = use_rt_d && (rt_d != 0) && (a_cnt < ready_at[rt_d] + (is_branch_d ? 1 : 0));
            e_raw   = issue_d && (e_rs || e_rt);
            e_stall = e_raw || ex_busy;
            e_flush = e_raw && !ex_busy;
            e_fa = (reg_write_m && wr_reg_m == rs_e && rs_e != 0) ? 2'b10 :
                   (reg_write_w && wr_reg_w == rs_e && rs_e != 0) ? 2'b01 : 2'b00;
            e_fb = (reg_write_m && wr_reg_m == rt_e && rt_e != 0) ? 2'b10 :
                   (reg_write_w && wr_reg_w == rt_e && rt_e != 0) ? 2'b01 : 2'b00;
            e_fad = reg_write_m && wr_reg_m == rs_d && rs_d != 0;
            e_fbd = reg_write_m && wr_reg_m == rt_d && rt_d != 0;
            e_ben = (ncyc >= WARMUP);
            for (int r = 0; r < NREG; r++) e_busy[r] = (r != 0) && (a_cnt <= ready_at[r]);

            n_vec++; if (stall_d !== e_stall) begin n_err++; $display("FAIL rnd stall_d i=%0d: got %b exp %b", i, stall_d, e_stall); end
            n_vec++; if (stall_f !== e_stall) begin n_err++; $display("FAIL rnd stall_f i=%0d: got %b exp %b", i, stall_f, e_stall); end
            n_vec++; if (flush_e !== e_flush) begin n_err++; $display("FAIL rnd flush_e i=%0d: got %b exp %b", i, flush_e, e_flush); end
            n_vec++; if (fwd_a_e !== e_fa) begin n_err++; $display("FAIL rnd fwd_a_e i=%0d: got %b exp %b", i, fwd_a_e, e_fa); end
            n_vec++; if (fwd_b_e !== e_fb) begin n_err++; $display("FAIL rnd fwd_b_e i=%0d: got %b exp %b", i, fwd_b_e, e_fb); end
            n_vec++; if (fwd_a_d !== e_fad) begin n_err++; $display("FAIL rnd fwd_a_d i=%0d: got %b exp %b", i, fwd_a_d, e_fad); end
            n_vec++; if (fwd_b_d !== e_fbd) begin n_err++; $display("FAIL rnd fwd_b_d i=%0d: got %b exp %b", i, fwd_b_d, e_fbd); end
            n_vec++; if (branch_en !== e_ben) begin n_err++; $display("FAIL rnd branch_en i=%0d: got %b exp %b", i, branch_en, e_ben); end
            n_vec++; if (sb_busy !== e_busy) begin n_err++; $display("FAIL rnd sb_busy i=%0d: got %h exp %h", i, sb_busy, e_busy); end
`ifdef HAZ_STATS_EN
            n_vec++; if (stall_cycles !== e_scyc) begin n_err++; $display("FAIL rnd stall_cycles i=%0d: got %0d exp %0d", i, stall_cycles, e_scyc); end
`endif
            $display("rnd %0d iss=%b br=%b rs=%0d rt=%0d wr=%b/%0d L=%0d busy=%b stall=%b",
                     i, issue_d, is_branch_d, rs_d, rt_d, wr_en_d, wr_reg_d, lat_d, ex_busy, stall_d);

            @(posedge clk);
            if (!ex_busy) begin
                if (issue_d && !e_stall && wr_en_d && wr_reg_d != 0) begin
                    ready_at[wr_reg_d] = a_cnt + int'(lat_d) + 1;
                end
                a_cnt++;
            end
`ifdef HAZ_STATS_EN
            if (e_stall) e_scyc = e_scyc + 32'd1;
`endif
            ncyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_load_use();
        test_branch();
        test_div_freeze();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
